vid_rd_sched: RTL and testbench
===============================

VID_RD_SCHED -- requirements
Module: vid_rd_sched

Interface
REQ-001 SHALL have parameter H_DISP, default 800, meaning active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 600, meaning active lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 64, meaning maximum 16-bit words per read burst (1..255).
REQ-004 SHALL have parameter FIFO_DEPTH, default 1024, meaning line FIFO capacity in words.
REQ-005 SHALL have parameter FLUSH_CYC, default 4, meaning cycles fifo_flush is held high.
REQ-006 SHALL have port pixel_clk, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port video_vs, input, 1, vertical sync from timing generator, active low.
REQ-009 SHALL have port data_req, input, 1, pixel request from timing generator.
REQ-010 SHALL have ports fifo_wr_cnt (input, 11, FIFO fill level) and fifo_empty (input, 1).
REQ-011 SHALL have port frame_base, input, 28, word address of next frame buffer.
REQ-012 SHALL have ports rd_req (output, 1), rd_addr (output, 28, word address) and rd_len (output, 8, burst words).
REQ-013 SHALL have ports rd_ack (input, 1, burst accepted) and rd_done (input, 1, last word written to FIFO).
REQ-014 SHALL have ports fifo_flush (output, 1), busy (output, 1), underflow_cnt (output, 16) and late_cnt (output, 8).

Function
REQ-015 SHALL detect frame start (fs) as a registered falling edge of video_vs: the cycle after video_vs goes 1 -> 0.
REQ-016 SHALL implement FSM states IDLE, FLUSH, CHECK, REQ, WAIT_DONE and DONE.
REQ-017 SHALL transition IDLE -> FLUSH on fs, latching frame_base into the address counter and loading words_left with H_DISP*V_DISP (20 bits).
REQ-018 SHALL hold fifo_flush high for exactly FLUSH_CYC cycles in FLUSH, then enter CHECK.
REQ-019 SHALL, in CHECK: enter DONE when words_left = 0; otherwise enter REQ when fifo_wr_cnt + len_next <= FIFO_DEPTH; otherwise remain in CHECK.
REQ-020 SHALL compute len_next as min(BURST_LEN, words_left).
REQ-021 SHALL, in REQ, hold rd_req high with rd_addr/rd_len stable until the cycle rd_ack = 1, then enter WAIT_DONE with rd_req low the following cycle.
REQ-022 SHALL, on rd_done in WAIT_DONE, add rd_len to the address (28-bit modulo wrap), subtract it from words_left, and return to CHECK.
REQ-023 SHALL hold DONE until fs, then enter FLUSH with new frame_base.
REQ-024 SHALL, on fs in CHECK or REQ (not acked), abort the frame, drop rd_req, increment late_cnt, and enter FLUSH.
REQ-025 SHALL, on fs in WAIT_DONE, set a pending flag, wait for rd_done, increment late_cnt, then enter FLUSH.
REQ-026 SHALL give rd_ack priority over fs when both occur in the same REQ cycle, treating the case as the WAIT_DONE case.
REQ-027 SHALL ignore rd_done outside WAIT_DONE and rd_ack outside REQ.
REQ-028 SHALL increment underflow_cnt each cycle data_req = 1 and fifo_empty = 1, saturating at 16'hFFFF.
REQ-029 SHALL saturate late_cnt at 8'hFF.
REQ-030 SHALL drive busy high in every state except IDLE and DONE.

Reset
REQ-031 SHALL, while sys_rst_n = 0, force state IDLE and set rd_req, fifo_flush, busy, rd_addr, rd_len, underflow_cnt, late_cnt, words_left, pending flag and vs edge register (to 1) to their idle values, independent of clock.
REQ-032 SHALL, after reset release, take no read action before the first fs.

Structure
REQ-033 SHALL place the state enum, the 28-bit address width and the 20-bit word-count width in shared package vid_rd_pkg.
REQ-034 SHALL be a single module with no sub-module; the FSM, address counter and statistics counters reside in vid_rd_sched.

Verification
REQ-035 SHALL check H_DISP=100, V_DISP=2, BURST_LEN=64, frame_base=0x1000, ack/done after 3 cycles -> bursts (0x1000,64), (0x1040,64), (0x1080,64), (0x10C0,8), then DONE with busy=0.
REQ-036 SHALL check fifo_wr_cnt=1000, FIFO_DEPTH=1024 -> rd_req stays 0; after fifo_wr_cnt drops to 960 -> rd_req asserts within 2 cycles.
REQ-037 SHALL check fs while in REQ with rd_ack held 0 -> rd_req low the next cycle, late_cnt=1, and fifo_flush high for exactly 4 cycles.
REQ-038 SHALL check fs during WAIT_DONE -> no new rd_req until rd_done, then flush, late_cnt=1, and first burst at the new frame_base.
REQ-039 SHALL check data_req=1 and fifo_empty=1 held for 70000 cycles -> underflow_cnt=0xFFFF.
REQ-040 SHALL check sys_rst_n asserted mid-burst -> all outputs at reset values in the same cycle, and no rd_req before the next fs.

Source files
------------

// File: rtl/vid_rd_pkg.sv
// Shared types and widths for the video frame-buffer read scheduler.
package vid_rd_pkg;

  localparam int ADDR_W = 28;
  localparam int WCNT_W = 20;
  localparam int LEN_W  = 8;
  localparam int FILL_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CHECK,
    ST_REQ,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/vid_rd_sched.sv
// Per-frame read-burst scheduler: refills the line FIFO from the frame buffer,
// restarting at every vertical sync and counting underflows and late frames.
module vid_rd_sched
  import vid_rd_pkg::*;
#(
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 600,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 1024,
  parameter int FLUSH_CYC  = 4
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic              video_vs,
  input  logic              data_req,
  input  logic [FILL_W-1:0] fifo_wr_cnt,
  input  logic              fifo_empty,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              fifo_flush,
  output logic              busy,
  output logic [15:0]       underflow_cnt,
  output logic [7:0]        late_cnt
);

  localparam logic [WCNT_W-1:0] FRAME_WORDS = WCNT_W'(H_DISP * V_DISP);
  localparam logic [7:0]        FLUSH_LAST  = 8'(FLUSH_CYC - 1);

  state_t              state_q, state_d;
  logic                vs_q, fs_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WCNT_W-1:0]   words_left_q;
  logic [LEN_W-1:0]    len_q;
  logic                pending_q;
  logic [7:0]          flush_cnt_q;
  logic [15:0]         underflow_q;
  logic [7:0]          late_q;

  logic [LEN_W-1:0]    len_next;
  logic [20:0]         fill_need;
  logic                fits;
  logic                load_frame, late_inc, advance, issue, set_pend;

  always_comb begin
    if (words_left_q < WCNT_W'(BURST_LEN)) len_next = words_left_q[LEN_W-1:0];
    else                                   len_next = LEN_W'(BURST_LEN);
    fill_need = 21'(fifo_wr_cnt) + 21'(len_next);
    fits      = (fill_need <= 21'(FIFO_DEPTH));
  end

  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    late_inc   = 1'b0;
    advance    = 1'b0;
    issue      = 1'b0;
    set_pend   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (fs_q) begin
          state_d    = ST_FLUSH;
          load_frame = 1'b1;
        end
      end
      ST_FLUSH: begin
        // A fresh sync during flush simply restarts it on the newer frame.
        if (fs_q)                    load_frame = 1'b1;
        else if (flush_cnt_q == '0)  state_d    = ST_CHECK;
      end
      ST_CHECK: begin
        if (fs_q) begin
          state_d    = ST_FLUSH;
          load_frame = 1'b1;
          late_inc   = 1'b1;
        end else if (words_left_q == '0) begin
          state_d = ST_DONE;
        end else if (fits) begin
          state_d = ST_REQ;
          issue   = 1'b1;
        end
      end
      ST_REQ: begin
        // An accepted burst must be drained before the frame can restart.
        if (rd_ack) begin
          state_d  = ST_WAIT_DONE;
          set_pend = fs_q;
        end else if (fs_q) begin
          state_d    = ST_FLUSH;
          load_frame = 1'b1;
          late_inc   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (rd_done) begin
          advance = 1'b1;
          if (pending_q || fs_q) begin
            state_d    = ST_FLUSH;
            load_frame = 1'b1;
            late_inc   = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          set_pend = fs_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b1;
      fs_q         <= 1'b0;
      addr_q       <= '0;
      words_left_q <= '0;
      len_q        <= '0;
      pending_q    <= 1'b0;
      flush_cnt_q  <= '0;
      underflow_q  <= '0;
      late_q       <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= video_vs;
      fs_q    <= vs_q & ~video_vs;

      if (load_frame) begin
        addr_q       <= frame_base;
        words_left_q <= FRAME_WORDS;
      end else if (advance) begin
        addr_q       <= addr_q + ADDR_W'(len_q);
        words_left_q <= words_left_q - WCNT_W'(len_q);
      end

      if (issue) len_q <= len_next;

      if (load_frame)                                  flush_cnt_q <= FLUSH_LAST;
      else if (state_q == ST_FLUSH && flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - 8'd1;

      if (load_frame)    pending_q <= 1'b0;
      else if (set_pend) pending_q <= 1'b1;

      if (late_inc && late_q != 8'hFF) late_q <= late_q + 8'd1;

      if (data_req && fifo_empty && underflow_q != 16'hFFFF)
        underflow_q <= underflow_q + 16'd1;
    end
  end

  assign rd_req        = (state_q == ST_REQ);
  assign fifo_flush    = (state_q == ST_FLUSH);
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign rd_addr       = addr_q;
  assign rd_len        = len_q;
  assign underflow_cnt = underflow_q;
  assign late_cnt      = late_q;

endmodule

// File: tb/tb_vid_rd_sched.sv
// Directed bench for vid_rd_sched with a burst scoreboard and a simple memory responder.
module tb_vid_rd_sched;
  import vid_rd_pkg::*;

  localparam int H  = 100;
  localparam int V  = 2;
  localparam int BL = 64;

  logic              pixel_clk = 1'b0;
  logic              sys_rst_n;
  logic              video_vs;
  logic              data_req;
  logic [FILL_W-1:0] fifo_wr_cnt;
  logic              fifo_empty;
  logic [ADDR_W-1:0] frame_base;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_done;
  logic              fifo_flush;
  logic              busy;
  logic [15:0]       underflow_cnt;
  logic [7:0]        late_cnt;

  always #5 pixel_clk = ~pixel_clk;

  vid_rd_sched #(
    .H_DISP(H), .V_DISP(V), .BURST_LEN(BL), .FIFO_DEPTH(1024), .FLUSH_CYC(4)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .video_vs(video_vs),
    .data_req(data_req), .fifo_wr_cnt(fifo_wr_cnt), .fifo_empty(fifo_empty),
    .frame_base(frame_base), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .rd_done(rd_done), .fifo_flush(fifo_flush), .busy(busy),
    .underflow_cnt(underflow_cnt), .late_cnt(late_cnt)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } burst_t;

  burst_t exp_q[$];
  int     vectors     = 0;
  int     miscompares = 0;
  int     late_exp    = 0;
  int     fl_n;
  logic   fl_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic fs_pulse();
    video_vs = 1'b0;
    step(1);
    video_vs = 1'b1;
  endtask

  // Expected burst list for one frame starting at base.
  task automatic push_frame(input logic [ADDR_W-1:0] base);
    burst_t b;
    int left = H * V;
    logic [ADDR_W-1:0] a = base;
    while (left > 0) begin
      b.addr = a;
      b.len  = LEN_W'((left < BL) ? left : BL);
      exp_q.push_back(b);
      a    = a + ADDR_W'(b.len);
      left = left - int'(b.len);
    end
  endtask

  task automatic measure_flush(output int n, output logic first_req);
    n = 0;
    first_req = 1'bx;
    for (int i = 0; i < 30; i++) begin
      if (fifo_flush === 1'b1) begin
        if (n == 0) first_req = rd_req;
        n++;
      end else if (n > 0) begin
        break;
      end
      step(1);
    end
  endtask

  task automatic serve_ack();
    burst_t e;
    int i = 0;
    while (rd_req !== 1'b1 && i < 50) begin
      step(1);
      i++;
    end
    if (rd_req !== 1'b1) begin
      chk("req_timeout", 32'(rd_req), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("unexpected_req", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("burst_addr", 32'(rd_addr), 32'(e.addr));
    chk("burst_len", 32'(rd_len), 32'(e.len));
    step(3);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    chk("req_drop_after_ack", 32'(rd_req), 32'd0);
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
  endtask

  task automatic serve_burst();
    serve_ack();
    step(2);
    pulse_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_flush"}, 32'(fifo_flush), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_rd_len"}, 32'(rd_len), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow_cnt), 32'd0);
    chk({tag, "_late"}, 32'(late_cnt), 32'd0);
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    video_vs    = 1'b1;
    data_req    = 1'b0;
    fifo_wr_cnt = '0;
    fifo_empty  = 1'b0;
    frame_base  = '0;
    rd_ack      = 1'b0;
    rd_done     = 1'b0;
    step(3);
    chk_reset_outputs("por");
    sys_rst_n = 1'b1;
    step(10);
    chk("idle_no_req", 32'(rd_req), 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Full frame: three full bursts and a short tail.
    frame_base = 28'h1000;
    push_frame(28'h1000);
    fs_pulse();
    measure_flush(fl_n, fl_req);
    chk("f1_flush_len", 32'(fl_n), 32'd4);
    repeat (4) serve_burst();
    step(2);
    chk("f1_done_busy", 32'(busy), 32'd0);
    chk("f1_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("f1_late", 32'(late_cnt), 32'd0);

    // FIFO nearly full holds off the request until space opens.
    fifo_wr_cnt = 11'd1000;
    frame_base  = 28'h2000;
    fs_pulse();
    measure_flush(fl_n, fl_req);
    step(10);
    chk("full_no_req", 32'(rd_req), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    fifo_wr_cnt = 11'd960;
    step(2);
    chk("space_req", 32'(rd_req), 32'd1);
    chk("space_addr", 32'(rd_addr), 32'h2000);
    chk("space_len", 32'(rd_len), 32'd64);

    // Sync while a request is outstanding and unacknowledged.
    frame_base = 28'h3000;
    fs_pulse();
    measure_flush(fl_n, fl_req);
    late_exp++;
    chk("abort_req_drop", 32'(fl_req), 32'd0);
    chk("abort_flush_len", 32'(fl_n), 32'd4);
    chk("abort_late", 32'(late_cnt), 32'(late_exp));
    fifo_wr_cnt = '0;
    exp_q.delete();
    push_frame(28'h3000);
    repeat (4) serve_burst();
    step(2);
    chk("f3_done_busy", 32'(busy), 32'd0);

    // Sync while a burst is in flight: finish it, then restart.
    frame_base = 28'h4000;
    push_frame(28'h4000);
    fs_pulse();
    measure_flush(fl_n, fl_req);
    serve_ack();
    frame_base = 28'h5000;
    fs_pulse();
    step(4);
    chk("pend_no_req", 32'(rd_req), 32'd0);
    chk("pend_busy", 32'(busy), 32'd1);
    chk("pend_no_flush", 32'(fifo_flush), 32'd0);
    chk("pend_late_hold", 32'(late_cnt), 32'(late_exp));
    pulse_done();
    measure_flush(fl_n, fl_req);
    late_exp++;
    chk("pend_flush_len", 32'(fl_n), 32'd4);
    chk("pend_late", 32'(late_cnt), 32'(late_exp));
    exp_q.delete();
    push_frame(28'h5000);
    repeat (4) serve_burst();
    step(2);
    chk("f5_done_busy", 32'(busy), 32'd0);

    // Underflow counting only when requested pixels find the FIFO empty.
    data_req   = 1'b1;
    fifo_empty = 1'b0;
    step(5);
    chk("uf_not_empty", 32'(underflow_cnt), 32'd0);
    fifo_empty = 1'b1;
    step(5);
    chk("uf_five", 32'(underflow_cnt), 32'd5);
    data_req   = 1'b0;
    fifo_empty = 1'b0;
    step(2);
    chk("uf_hold", 32'(underflow_cnt), 32'd5);

    // Asynchronous reset in the middle of a burst.
    frame_base = 28'h6000;
    exp_q.delete();
    push_frame(28'h6000);
    fs_pulse();
    measure_flush(fl_n, fl_req);
    serve_ack();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    step(1);
    sys_rst_n = 1'b1;
    late_exp = 0;
    step(10);
    chk("post_rst_no_req", 32'(rd_req), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);
    exp_q.delete();
    push_frame(28'h6000);
    fs_pulse();
    measure_flush(fl_n, fl_req);
    chk("post_rst_flush_len", 32'(fl_n), 32'd4);
    serve_ack();
    step(2);
    pulse_done();

    // Long underflow run saturates the counter.
    data_req   = 1'b1;
    fifo_empty = 1'b1;
    step(70000);
    chk("uf_saturate", 32'(underflow_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
